// File: rtl/bram_dp_init_if.sv
// Port A (host read/write) and port B (FIR read-only) bus for bram_dp_init,
// plus the READY/ERR status lines.
interface bram_dp_init_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12
);
   logic                  ena;
   logic [DATA_W/8-1:0]   wea;
   logic [ADDR_W-1:0]     aa;
   logic [DATA_W-1:0]     dia;
   logic [DATA_W-1:0]     doa;
   logic                  enb;
   logic [ADDR_W-1:0]     ab;
   logic [DATA_W-1:0]     dob;
   logic                  ready;
   logic                  err;

   modport master (output ena, wea, aa, dia, enb, ab,
                   input  doa, dob, ready, err);
   modport slave  (input  ena, wea, aa, dia, enb, ab,
                   output doa, dob, ready, err);
endinterface

// File: rtl/bram_dp_init.sv
// Dual-port byte-strobed RAM, zeroed by a clear sequencer after reset, with a sticky
// out-of-range flag. Define BRAM_OUTREG_EN for an extra output register (2-edge reads).
module bram_dp_init #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 12
) (
   input  logic           clk,
   input  logic           rst,
   bram_dp_init_if.slave  bus
);
   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
   localparam int IDX_W = ADDR_W - OFF_W;
   localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEPTH - 1);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   clr_idx;
   logic               clr_we, run;
   logic [DATA_W-1:0]  mem [DEPTH];
   logic [IDX_W-1:0]   idx_a, idx_b;
   logic               hit_a, hit_b, oor;
   logic [DATA_W-1:0]  doa_q, dob_q;
   logic               err_q;

   assign idx_a = bus.aa[ADDR_W-1:OFF_W];
   assign idx_b = bus.ab[ADDR_W-1:OFF_W];
   assign hit_a = bus.ena && (idx_a < DEPTH_I);
   assign hit_b = bus.enb && (idx_b < DEPTH_I);
   assign oor   = run && ((bus.ena && !hit_a) || (bus.enb && !hit_b));

   always_comb begin
      state_nxt = state;
      clr_we    = 1'b0;
      run       = 1'b0;
      unique case (state)
         CLEAR: begin
            clr_we = 1'b1;
            if (clr_idx == LAST) state_nxt = RUN;
         end
         RUN: run = 1'b1;
         default: state_nxt = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_idx <= '0;
      end else begin
         state <= state_nxt;
         if (clr_we) clr_idx <= clr_idx + 1'b1;
      end
   end

   // Array has no reset; the sequencer zeroes it one word per cycle instead.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (clr_we) begin
            mem[clr_idx] <= '0;
         end else if (run && hit_a) begin
            for (int i = 0; i < BYTES; i++)
               if (bus.wea[i]) mem[idx_a[CNT_W-1:0]][8*i +: 8] <= bus.dia[8*i +: 8];
         end
      end
   end

   // Reads sample the array before this edge's write lands (read-before-write).
   always_ff @(posedge clk) begin
      if (rst) begin
         doa_q <= '0;
         dob_q <= '0;
         err_q <= 1'b0;
      end else begin
         doa_q <= (run && hit_a) ? mem[idx_a[CNT_W-1:0]] : '0;
         dob_q <= (run && hit_b) ? mem[idx_b[CNT_W-1:0]] : '0;
         if (oor) err_q <= 1'b1;
      end
   end

`ifdef BRAM_OUTREG_EN
   logic [DATA_W-1:0] doa_r, dob_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         doa_r <= '0;
         dob_r <= '0;
      end else begin
         doa_r <= doa_q;
         dob_r <= dob_q;
      end
   end

   assign bus.doa = doa_r;
   assign bus.dob = dob_r;
`else
   assign bus.doa = doa_q;
   assign bus.dob = dob_q;
`endif

   assign bus.ready = run;
   assign bus.err   = err_q;
endmodule

// File: tb/tb_bram_dp_init.sv
// Directed + random bench for bram_dp_init against an array-based reference model.
module tb_bram_dp_init;
   localparam int DEPTH = 32;
`ifdef BRAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bram_dp_init_if #(.DATA_W(32), .ADDR_W(12)) bus ();

   bram_dp_init #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          ncmp = 0;
   int          nfail = 0;
   logic [31:0] ref_mem [DEPTH];
   int          clear_left = DEPTH;
   bit          ref_err = 1'b0;
   logic [31:0] pa = '0, pb = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: drive, advance the model, then check all outputs 1ns after the edge.
   task automatic step(input bit r, input bit ea, input logic [3:0] wa, input logic [11:0] a_ad,
                       input logic [31:0] da, input bit eb, input logic [11:0] b_ad);
      int ia, ib;
      bit rdy;
      logic [31:0] ra, rb, xa, xb;
      rst = r; bus.ena = ea; bus.wea = wa; bus.aa = a_ad; bus.dia = da;
      bus.enb = eb; bus.ab = b_ad;
      ia  = int'(a_ad) / 4;
      ib  = int'(b_ad) / 4;
      rdy = (clear_left == 0);
      ra  = (!r && rdy && ea && ia < DEPTH) ? ref_mem[ia] : 32'h0;
      rb  = (!r && rdy && eb && ib < DEPTH) ? ref_mem[ib] : 32'h0;
      if (r) ref_err = 1'b0;
      else if (rdy && ((ea && ia >= DEPTH) || (eb && ib >= DEPTH))) ref_err = 1'b1;
      if (!r && rdy && ea && ia < DEPTH)
         for (int b = 0; b < 4; b++)
            if (wa[b]) ref_mem[ia][8*b +: 8] = da[8*b +: 8];
      if (r) clear_left = DEPTH;
      else if (clear_left > 0) begin
         clear_left--;
         if (clear_left == 0) foreach (ref_mem[k]) ref_mem[k] = 32'h0;
      end
      if (LAT == 1) begin
         xa = ra; xb = rb;
      end else begin
         xa = r ? 32'h0 : pa; xb = r ? 32'h0 : pb;
         pa = ra; pb = rb;
      end
      @(posedge clk); #1;
      chk("doa", bus.doa, xa);
      chk("dob", bus.dob, xb);
      chk("ready", {31'b0, bus.ready}, {31'b0, clear_left == 0});
      chk("err", {31'b0, bus.err}, {31'b0, ref_err});
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0, 12'h0);
   endtask

   task automatic settle();
      repeat (LAT - 1) idle();
   endtask

   function automatic logic [11:0] rand_addr();
      if ($urandom_range(0, 15) == 0) return 12'($urandom_range(0, 4095));
      return 12'($urandom_range(0, 127));
   endfunction

   task automatic rand_run(input int n);
      for (int k = 0; k < n; k++)
         step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_addr(),
              $urandom(), 1'($urandom_range(0, 1)), rand_addr());
   endtask

   initial begin
      // Clear after a 3-cycle reset
      repeat (3) step(1'b1, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0, 12'h0);
      chk("rst_doa", bus.doa, 32'h0);
      chk("rst_err", {31'b0, bus.err}, 32'h0);
      repeat (DEPTH - 1) idle();
      chk("ready_pre", {31'b0, bus.ready}, 32'h0);
      idle();
      chk("ready_rise", {31'b0, bus.ready}, 32'h1);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1, 12'(i * 4));
      settle();

      // Byte strobes
      step(1'b0, 1'b1, 4'hF, 12'h008, 32'hDEADBEEF, 1'b0, 12'h0);
      step(1'b0, 1'b1, 4'h1, 12'h008, 32'h00000011, 1'b0, 12'h0);
      step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1, 12'h008);
      settle();
      chk("byte_strobe", bus.dob, 32'hDEADBE11);
      idle();
      chk("idle_zero", bus.dob, 32'h0);

      // Same-word collision: B sees the old word, then the new one
      step(1'b0, 1'b1, 4'hF, 12'h00C, 32'h12345678, 1'b0, 12'h0);
      step(1'b0, 1'b1, 4'hF, 12'h00C, 32'hCAFEF00D, 1'b1, 12'h00C);
      settle();
      chk("collide_old", bus.dob, 32'h12345678);
      step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1, 12'h00E);
      settle();
      chk("collide_new", bus.dob, 32'hCAFEF00D);

      // Out-of-range
      step(1'b0, 1'b1, 4'hF, 12'h080, 32'hFFFFFFFF, 1'b0, 12'h0);
      chk("oor_err", {31'b0, bus.err}, 32'h1);
      step(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1, 12'h080);
      settle();
      chk("oor_read", bus.dob, 32'h0);
      step(1'b0, 1'b1, 4'h0, 12'h000, 32'h0, 1'b1, 12'h000);
      settle();
      chk("oor_word0", bus.doa, 32'h0);
      chk("oor_sticky", {31'b0, bus.err}, 32'h1);

      rand_run(300);

      // Reset in the middle of a clear, at index 10
      repeat (2) step(1'b1, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0, 12'h0);
      chk("rst_err_clr", {31'b0, bus.err}, 32'h0);
      repeat (10) idle();
      step(1'b1, 1'b1, 4'hF, 12'h004, 32'h55AA55AA, 1'b1, 12'h004);
      repeat (DEPTH - 1) idle();
      chk("ready_pre2", {31'b0, bus.ready}, 32'h0);
      idle();
      chk("ready_rise2", {31'b0, bus.ready}, 32'h1);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 4'h0, 12'(i * 4), 32'h0, 1'b1, 12'(i * 4));
      settle();

      rand_run(300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
